// File: rtl/tag_ctrl_pkg.sv
// Shared types and sizing for the tag array access controller.
//   TAG_ADDR_W / TAG_DATA_W / TAG_DEPTH : default geometry of the 128x21 tag macro
//   tag_ctrl_state_t                    : controller state (sweep vs. normal run)
//   tag_word_t                          : one tag entry (valid/dirty/tag bits)
package tag_ctrl_pkg;

  localparam int TAG_ADDR_W = 7;
  localparam int TAG_DATA_W = 21;
  localparam int TAG_DEPTH  = 1 << TAG_ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } tag_ctrl_state_t;

  typedef logic [TAG_DATA_W-1:0] tag_word_t;

endpackage

// File: rtl/tag_init_seq.sv
// Post-reset sweep sequencer for the tag array.
// Owns the sweep index; the parent decides when the sweep is active and
// muxes the sweep access onto the macro port.
//   clk, rst    : clock, synchronous active-high reset (index back to 0)
//   active      : sweep in progress (parent is in INIT)
//   sweep_addr  : entry being initialised this cycle
//   sweep_din   : value written to that entry
//   done        : the last entry is being issued this cycle
module tag_init_seq
  import tag_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = TAG_ADDR_W,
  parameter int                    DATA_WIDTH = TAG_DATA_W,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  output logic [ADDR_WIDTH-1:0] sweep_addr,
  output logic [DATA_WIDTH-1:0] sweep_din,
  output logic                  done
);

  logic [ADDR_WIDTH-1:0] cnt;

  // Wraps back to 0 after the last entry, so the next sweep (after a later
  // reset) starts cleanly even without the reset clearing it.
  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (active) cnt <= cnt + 1'b1;
  end

  assign sweep_addr = cnt;
  assign sweep_din  = INIT_VALUE;
  assign done       = active & (cnt == '1);

endmodule

// File: rtl/tag_array_ctrl.sv
// Single-port access controller for the 128x21 OpenRAM tag macro.
// After reset every entry is swept to INIT_VALUE; then one access per cycle
// is granted, write over read, with read data returned one cycle after grant.
// Optional macro TAG_ARB_STARVE_GUARD_EN: forces a read grant over a pending
// write once a read has been denied STARVE_LIMIT consecutive cycles.
// Ports:
//   clk, rst                    : clock (also macro clk0), sync active-high reset
//   rd_req/rd_addr/rd_gnt       : lookup read request, index, combinational grant
//   rd_rvalid/rd_rdata          : read data valid (registered) and data (macro dout)
//   wr_req/wr_addr/wr_data/wr_gnt : fill/update write request and combinational grant
//   init_done                   : sweep complete, requests may be granted
//   sram_csb/web/addr/din/dout  : macro port 0 (csb/web active low)
module tag_array_ctrl
  import tag_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = TAG_ADDR_W,
  parameter int                    DATA_WIDTH   = TAG_DATA_W,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  init_done,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  tag_ctrl_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [DATA_WIDTH-1:0] sweep_din;
  logic                  sweep_done;

  // Last driven macro controls; replayed on idle cycles so web/addr/din
  // only move when an access is actually issued.
  logic                  hold_web;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_din;

  logic                  vld_pipe;
  logic                  force_rd;

  tag_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .active     (state == INIT),
    .sweep_addr (sweep_addr),
    .sweep_din  (sweep_din),
    .done       (sweep_done)
  );

`ifdef TAG_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  // Counts consecutive RUN cycles where a read waited; any grant or a
  // dropped request restarts the count.
  always_ff @(posedge clk) begin
    if (rst || state != RUN)   starve_cnt <= '0;
    else if (rd_gnt || !rd_req) starve_cnt <= '0;
    else                        starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_rd = rd_req & (starve_cnt == STARVE_MAX);
`else
  assign force_rd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Arbitration and macro port mux. rst gates every grant/select so the
  // macro is deselected in the reset cycle even if the state is still RUN.
  always_comb begin
    state_nxt = state;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    sram_csb  = 1'b1;
    sram_web  = hold_web;
    sram_addr = hold_addr;
    sram_din  = hold_din;
    if (!rst) begin
      case (state)
        INIT: begin
          sram_csb  = 1'b0;
          sram_web  = 1'b0;
          sram_addr = sweep_addr;
          sram_din  = sweep_din;
          if (sweep_done) state_nxt = RUN;
        end
        RUN: begin
          if (rd_req && (force_rd || !wr_req)) begin
            rd_gnt    = 1'b1;
            sram_csb  = 1'b0;
            sram_web  = 1'b1;
            sram_addr = rd_addr;
          end else if (wr_req) begin
            wr_gnt    = 1'b1;
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = wr_addr;
            sram_din  = wr_data;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_web  <= 1'b1;
      hold_addr <= '0;
      hold_din  <= '0;
    end else if (!sram_csb) begin
      hold_web  <= sram_web;
      hold_addr <= sram_addr;
      hold_din  <= sram_din;
    end
  end

  // Macro presents read data the cycle after the access is latched.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= 1'b0;
    else     vld_pipe <= rd_gnt;
  end

  assign rd_rvalid = vld_pipe;
  assign rd_rdata  = sram_dout;
  assign init_done = (state == RUN) & ~rst;

endmodule

// File: tb/tb_tag_array_ctrl.sv
module tb_tag_array_ctrl;

  localparam int AW = 7;
  localparam int DW = 21;
  localparam int DEPTH = 128;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_gnt, wr_gnt, rd_rvalid, init_done;
  logic [DW-1:0] rd_rdata;
  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tag_array_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE('0), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Simple macro stand-in: inputs registered at posedge, read data out the next cycle.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [DW-1:0] gold [DEPTH];
  int            m_cnt = 0;
  bit            m_done = 0;
  bit            m_rv = 0;
  logic [DW-1:0] m_rd;
  int            m_starve = 0;
  logic          m_lweb;
  logic [AW-1:0] m_laddr;
  logic [DW-1:0] m_ldin;
  bit            g_rd = 0, g_wr = 0;

  always @(negedge clk) begin
    bit e_rd, e_wr, frc;
    g_rd = rd_gnt;
    g_wr = wr_gnt;
    if (rst) begin
      chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_csb", sram_csb, 1);
      chk("rst_init_done", init_done, 0);
      m_cnt = 0; m_done = 0; m_rv = 0; m_starve = 0;
    end else begin
      chk("rvalid", rd_rvalid, m_rv);
      if (m_rv) chk("rdata", rd_rdata, m_rd);
      m_rv = 0;
      chk("init_done", init_done, m_done);
      if (!m_done) begin
        chk("sweep_rd_gnt", rd_gnt, 0);
        chk("sweep_wr_gnt", wr_gnt, 0);
        chk("sweep_csb", sram_csb, 0);
        chk("sweep_web", sram_web, 0);
        chk("sweep_addr", sram_addr, m_cnt);
        chk("sweep_din", sram_din, 0);
        gold[m_cnt] = '0;
        m_lweb = 0; m_laddr = AW'(m_cnt); m_ldin = '0;
        if (m_cnt == DEPTH - 1) m_done = 1;
        m_cnt++;
      end else begin
`ifdef TAG_ARB_STARVE_GUARD_EN
        frc = rd_req && (m_starve == LIMIT);
`else
        frc = 0;
`endif
        e_wr = wr_req && !frc;
        e_rd = rd_req && (!wr_req || frc);
        chk("rd_gnt", rd_gnt, e_rd);
        chk("wr_gnt", wr_gnt, e_wr);
        chk("csb", sram_csb, !(e_rd || e_wr));
        if (e_wr) begin
          chk("wr_web", sram_web, 0);
          chk("wr_addr", sram_addr, wr_addr);
          chk("wr_din", sram_din, wr_data);
          gold[wr_addr] = wr_data;
          m_lweb = 0; m_laddr = wr_addr; m_ldin = wr_data;
        end else if (e_rd) begin
          chk("rd_web", sram_web, 1);
          chk("rd_addr", sram_addr, rd_addr);
          m_rv = 1;
          m_rd = gold[rd_addr];
          m_lweb = 1; m_laddr = rd_addr;
        end else begin
          chk("idle_web", sram_web, m_lweb);
          chk("idle_addr", sram_addr, m_laddr);
          chk("idle_din", sram_din, m_ldin);
        end
        if (rd_req && !e_rd) m_starve++;
        else                 m_starve = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep(output int n, output int rg);
    n = 0; rg = 0;
    while (n < 300) begin
      @(negedge clk);
      if (init_done) break;
      if (rd_gnt) rg++;
      n++;
    end
    cyc();
  endtask

  initial begin
    int n, rg, first;
    rst = 1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    cyc(); cyc();
    // Sweep with a read held pending throughout.
    rst = 0; rd_req = 1; rd_addr = 7'h33;
    count_sweep(n, rg);
    chk("sweep_cycles", n, 128);
    chk("sweep_rd_gnt_cnt", rg, 0);
    rd_req = 0;
    cyc();

    // Write then read of the same index.
    wr_req = 1; wr_addr = 7'h05; wr_data = 21'h1ABCD;
    cyc();
    wr_req = 0; rd_req = 1; rd_addr = 7'h05;
    @(negedge clk); chk("wr_rd_gnt", rd_gnt, 1);
    cyc();
    rd_req = 0;
    @(negedge clk); chk("wr_rd_rvalid", rd_rvalid, 1); chk("wr_rd_data", rd_rdata, 21'h1ABCD);
    cyc();

    // Simultaneous read and write to one index.
    rd_req = 1; wr_req = 1; rd_addr = 7'h10; wr_addr = 7'h10; wr_data = 21'h00F0F;
    @(negedge clk); chk("sim_wr_gnt", wr_gnt, 1); chk("sim_rd_gnt0", rd_gnt, 0);
    cyc();
    wr_req = 0;
    @(negedge clk); chk("sim_rd_gnt1", rd_gnt, 1);
    cyc();
    rd_req = 0;
    @(negedge clk); chk("sim_rvalid", rd_rvalid, 1); chk("sim_rdata", rd_rdata, 21'h00F0F);
    cyc();

    // Back-to-back: write addr i with i+1, then stream 8 reads.
    for (int i = 0; i < 8; i++) begin
      wr_req = 1; wr_addr = AW'(i); wr_data = DW'(i + 1);
      cyc();
    end
    wr_req = 0;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1; rd_addr = AW'(i);
      @(negedge clk);
      if (i > 0) begin chk("b2b_rvalid", rd_rvalid, 1); chk("b2b_rdata", rd_rdata, i); end
      cyc();
    end
    rd_req = 0;
    @(negedge clk); chk("b2b_rvalid_last", rd_rvalid, 1); chk("b2b_rdata_last", rd_rdata, 8);
    cyc(); cyc();

    // Continuous read and write contention.
    rd_req = 1; wr_req = 1; rd_addr = 7'h21; wr_addr = 7'h20; wr_data = 21'h0BEEF;
    rg = 0; first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_gnt) begin rg++; if (first == 0) first = k; end
      cyc();
    end
    rd_req = 0; wr_req = 0;
`ifdef TAG_ARB_STARVE_GUARD_EN
    chk("starve_first", first, 5);
    chk("starve_count", rg, 4);
`else
    chk("starve_count", rg, 0);
`endif
    cyc(); cyc();

    // Randomised traffic, requests held until granted.
    for (int c = 0; c < 800; c++) begin
      if (!rd_req || g_rd) begin
        rd_req = ($urandom_range(0, 99) < 60);
        rd_addr = AW'($urandom_range(0, 15));
      end
      if (!wr_req || g_wr) begin
        wr_req = ($urandom_range(0, 99) < 45);
        wr_addr = AW'($urandom_range(0, 15));
        wr_data = DW'($urandom);
      end
      cyc();
    end
    rd_req = 0; wr_req = 0;
    cyc(); cyc();

    // Reset mid-run, then abort the sweep at index 60.
    rst = 1; cyc(); cyc();
    rst = 0;
    for (int k = 0; k < 60; k++) cyc();
    @(negedge clk); chk("abort_addr", sram_addr, 60);
    cyc();
    rst = 1; cyc();
    rst = 0;
    count_sweep(n, rg);
    chk("restart_cycles", n, 128);
    cyc();
    for (int k = 0; k < 4; k++) begin
      rd_req = 1; rd_addr = AW'($urandom_range(0, 127));
      cyc();
    end
    rd_req = 0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
